kiwi_run_monitor: RTL

- Synthesisable, multi-channel successor to the single-DUT finish detector in the simulation wrappers.
- Watches NCH abend-syndrome buses and applies a per-channel debounce/settle delay.
- Enforces a cycle timeout and captures the first completion: channel, code, cause and tick count.
- Sits beside the DUT(s) in FPGA or simulation builds so that the host or bench polls one done/code interface.

---
 rtl/kiwi_monitor_pkg.sv | 17 +
 rtl/kiwi_abend_debounce.sv | 62 ++++++
 rtl/kiwi_run_monitor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/kiwi_monitor_pkg.sv
// Shared types and constants for the kiwi run monitor.
// Syndrome encodings, completion causes and the default timeout code.
package kiwi_monitor_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_SYNDROME = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } done_cause_e;

  // Replicated to SYND_W: all-zero is running, all-ones is idle.
  localparam logic SYND_RUNNING = 1'b0;
  localparam logic SYND_IDLE    = 1'b1;

  localparam int unsigned TIMEOUT_CODE_DEF = 32'h0000_00FE;

endpackage

// File: rtl/kiwi_abend_debounce.sv
// One syndrome channel: raw finish detect, settle shifter and
// the register holding the last non-idle syndrome seen.
module kiwi_abend_debounce
  import kiwi_monitor_pkg::*;
#(
  parameter int DEBOUNCE = 8,
  parameter bit STICKY   = 1'b1,
  parameter int SYND_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [SYND_W-1:0] i_syn,
  output logic              o_settled,
  output logic [SYND_W-1:0] o_last_code
);

  localparam logic [SYND_W-1:0] L_RUN  = {SYND_W{SYND_RUNNING}};
  localparam logic [SYND_W-1:0] L_IDLE = {SYND_W{SYND_IDLE}};

  logic                w_fin;
  logic                w_head;
  logic [DEBOUNCE-1:0] w_sh_nxt;
  logic [DEBOUNCE-1:0] r_sh;
  logic [SYND_W-1:0]   r_code;

  assign w_fin = i_enable
              && (i_syn != L_RUN)
              && (i_syn != L_IDLE);

  // Sticky mode keeps feeding a one once any finish was seen.
  assign w_head = STICKY ? (r_sh[0] | w_fin) : w_fin;

  generate
    if (DEBOUNCE == 1) begin : g_one
      assign w_sh_nxt = w_head;
    end else begin : g_many
      assign w_sh_nxt = {r_sh[DEBOUNCE-2:0], w_head};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh   <= '0;
      r_code <= '0;
    end else if (i_clear) begin
      r_sh   <= '0;
      r_code <= '0;
    end else if (i_run) begin
      r_sh <= i_enable ? w_sh_nxt : '0;
      if (w_fin) begin
        r_code <= i_syn;
      end
    end
  end

  assign o_settled   = STICKY ? r_sh[DEBOUNCE-1] : (&r_sh);
  assign o_last_code = r_code;

endmodule

// File: rtl/kiwi_run_monitor.sv
// Multi-channel run monitor: debounced syndrome finish, cycle
// timeout and first-completion capture behind one done/code port.
module kiwi_run_monitor
  import kiwi_monitor_pkg::*;
#(
  parameter int          NCH          = 4,
  parameter int          SYND_W       = 8,
  parameter int          DEBOUNCE     = 8,
  parameter bit          STICKY       = 1'b1,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int          TICK_W       = 32,
  parameter int unsigned TIMEOUT_CODE = TIMEOUT_CODE_DEF
) (
  input  logic                    my_clock,
  input  logic                    my_reset,
  input  logic [NCH*SYND_W-1:0]   hpr_abend_syndrome,
  input  logic [NCH-1:0]          ch_enable,
  input  logic                    clear,
  output logic                    done,
  output logic [1:0]              done_cause,
  output logic [((NCH>1)?$clog2(NCH):1)-1:0] done_channel,
  output logic [SYND_W-1:0]       done_code,
  output logic [TICK_W-1:0]       clock_ticks,
  output logic [NCH-1:0]          ch_finished
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [SYND_W-1:0] L_RUN  = {SYND_W{SYND_RUNNING}};
  localparam logic [SYND_W-1:0] L_IDLE = {SYND_W{SYND_IDLE}};
  localparam logic [SYND_W-1:0] L_TO_CODE = SYND_W'(TIMEOUT_CODE);
  localparam logic [TICK_W:0]   L_TO = (TICK_W+1)'(TIMEOUT);

  logic [0:0]        r_state;
  logic              r_done;
  done_cause_e       r_cause;
  logic [CW-1:0]     r_chan;
  logic [SYND_W-1:0] r_code;
  logic [TICK_W-1:0] r_ticks;

  logic              w_run;
  logic [NCH-1:0]    w_settled;
  logic [SYND_W-1:0] w_last [NCH];
  logic              w_hit;
  logic [CW-1:0]     w_sel;
  logic [SYND_W-1:0] w_s;
  logic [SYND_W-1:0] w_cap;
  logic              w_to_hit;

  assign w_run = (r_state == ST_RUN);

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      kiwi_abend_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .STICKY   (STICKY),
        .SYND_W   (SYND_W)
      ) u_db (
        .i_clk       (my_clock),
        .i_rst_n     (my_reset),
        .i_run       (w_run),
        .i_clear     (clear),
        .i_enable    (ch_enable[c]),
        .i_syn       (hpr_abend_syndrome[c*SYND_W +: SYND_W]),
        .o_settled   (w_settled[c]),
        .o_last_code (w_last[c])
      );
    end
  endgenerate

  // Walk downwards so the lowest settled index is the last to win.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_s   = '0;
    w_cap = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_settled[c]) begin
        w_hit = 1'b1;
        w_sel = CW'(c);
        w_s   = hpr_abend_syndrome[c*SYND_W +: SYND_W];
        w_cap = ((w_s == L_RUN) || (w_s == L_IDLE)) ? w_last[c] : w_s;
      end
    end
  end

  assign w_to_hit = (TIMEOUT != 0)
                 && (({1'b0, r_ticks} + (TICK_W+1)'(1)) == L_TO);

  always_ff @(posedge my_clock or negedge my_reset) begin
    if (!my_reset) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
      r_cause <= CAUSE_NONE;
      r_chan  <= '0;
      r_code  <= '0;
      r_ticks <= '0;
    end else if (clear) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
      r_cause <= CAUSE_NONE;
      r_chan  <= '0;
      r_code  <= '0;
      r_ticks <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_ticks != '1) begin
        r_ticks <= r_ticks + TICK_W'(1);
      end
      if (w_hit) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_cause <= CAUSE_SYNDROME;
        r_chan  <= w_sel;
        r_code  <= w_cap;
      end else if (w_to_hit) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_cause <= CAUSE_TIMEOUT;
        r_chan  <= '0;
        r_code  <= L_TO_CODE;
      end
    end
  end

  assign done         = r_done;
  assign done_cause   = r_cause;
  assign done_channel = r_chan;
  assign done_code    = r_code;
  assign clock_ticks  = r_ticks;
  assign ch_finished  = w_settled;

endmodule
